// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the M-extension execute unit.
// Holds the operand width, the special-case result constants, the Funct3
// opcode enum, the FSM state enum and small opcode-decode helpers.
package rv32_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  // IDLE must encode as zero so the reset value is the idle state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_t;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_t;

  // rs1 is treated as signed (MUL low word is sign-agnostic, so signed is fine)
  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed
  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input muldiv_op_t op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter_step.sv
// One radix-2 iteration of the unsigned multiply / divide datapath.
// Ports:
//   mode     STEP_MUL: shift-add step; STEP_DIV: restoring shift-subtract step
//   acc      64-bit accumulator {hi, lo}
//   operand  multiplicand (mul) or divisor (div), magnitude only
//   acc_next accumulator after this iteration
// Mul: lo holds the multiplier, consumed LSB first; hi accumulates partial sums.
// Div: hi is the partial remainder, lo shifts the dividend out and quotient in.
module muldiv_iter_step
  import rv32_pkg::*;
(
  input  step_mode_t            mode,
  input  logic [2*XLEN-1:0]     acc,
  input  logic [XLEN-1:0]       operand,
  output logic [2*XLEN-1:0]     acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  always_comb begin
    sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh   = acc[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, operand};
    acc_next = acc;
    if (mode == STEP_MUL) begin
      // carry out of the add becomes the new MSB as everything shifts right
      acc_next = {sum, acc[XLEN-1:1]};
    end else if (!diff[XLEN]) begin
      // trial subtract fits: keep difference, quotient bit 1
      acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// RV32M execute-stage multiply/divide unit (iterative, one bit per cycle).
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Start, Flush          launch (sampled in IDLE) / pipeline kill
//   Funct3                M-extension opcode
//   Operand_A, Operand_B  rs1 / rs2 values
//   Busy                  high while an op is in CALC or DONE
//   Done                  one-cycle pulse, Result valid
//   Result                op result, held until overwritten by a later op
// Build option: FAST_MUL_EN makes all multiplies complete in one cycle using a
// hardware 33x33 signed multiplier; division stays iterative.
module mul_div_unit
  import rv32_pkg::*;
(
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            Start,
  input  logic            Flush,
  input  logic [2:0]      Funct3,
  input  logic [31:0]     Operand_A,
  input  logic [31:0]     Operand_B,
  output logic            Busy,
  output logic            Done,
  output logic [31:0]     Result
);

  muldiv_state_t    state;
  muldiv_op_t       op;
  logic [CNT_W-1:0] count;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]  opnd;
  logic             neg_q;
  logic             neg_r;

  muldiv_op_t       op_in;
  logic             a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0]  a_abs, b_abs;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]  fix_res;

  // Decode of the incoming op: magnitudes, sign flags, fast-path conditions
  always_comb begin
    op_in = muldiv_op_t'(Funct3);
    a_neg = op_a_signed(op_in) & Operand_A[XLEN-1];
    b_neg = op_b_signed(op_in) & Operand_B[XLEN-1];
    a_abs = a_neg ? XLEN'(32'd0 - Operand_A) : Operand_A;
    b_abs = b_neg ? XLEN'(32'd0 - Operand_B) : Operand_B;
    div0  = Funct3[2] && (Operand_B == '0);
    ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
            (Operand_A == INT_MIN) && (Operand_B == '1);
  end

  muldiv_iter_step u_step (
    .mode     (step_mode_t'(op[2])),
    .acc      (acc),
    .operand  (opnd),
    .acc_next (acc_next)
  );

  // Sign fix applied to the final iteration's accumulator
  always_comb begin
    prod_fix = neg_q ? (64'd0 - acc_next) : acc_next;
    case (op)
      OP_MUL:                       fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_res = neg_q ? XLEN'(32'd0 - acc_next[XLEN-1:0])
                                                    : acc_next[XLEN-1:0];
      default:                      fix_res = neg_r ? XLEN'(32'd0 - acc_next[2*XLEN-1:XLEN])
                                                    : acc_next[2*XLEN-1:XLEN];
    endcase
  end

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  logic [XLEN-1:0]   fast_res;

  // 33x33 signed multiply, written on sign-extended operands truncated to 64 bits
  always_comb begin
    fast_prod = {{XLEN{op_a_signed(op_in) & Operand_A[XLEN-1]}}, Operand_A} *
                {{XLEN{op_b_signed(op_in) & Operand_B[XLEN-1]}}, Operand_B};
    fast_res  = (op_in == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // FSM, iteration counter, operand latch and result register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state  <= IDLE;
      op     <= OP_MUL;
      count  <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start && !Flush) begin
            op    <= op_in;
            count <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            Busy  <= 1'b1;
            if (div0) begin
              state  <= DONE;
              Done   <= 1'b1;
              Result <= op_is_rem(op_in) ? Operand_A : DIV0_QUOT;
            end else if (ovf) begin
              state  <= DONE;
              Done   <= 1'b1;
              Result <= op_is_rem(op_in) ? '0 : INT_MIN;
`ifdef FAST_MUL_EN
            end else if (!Funct3[2]) begin
              state  <= DONE;
              Done   <= 1'b1;
              Result <= fast_res;
`endif
            end else begin
              state <= CALC;
              // mul: multiplier in lo, multiplicand as operand; div: dividend in lo
              acc   <= Funct3[2] ? {32'd0, a_abs} : {32'd0, b_abs};
              opnd  <= Funct3[2] ? b_abs : a_abs;
            end
          end
        end
        CALC: begin
          if (Flush) begin
            state <= IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
          end else begin
            acc <= acc_next;
            if (count == 5'd31) begin
              state  <= DONE;
              Done   <= 1'b1;
              Result <= fix_res;
            end else begin
              count <= count + 5'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected result and
// completion cycle; a negedge monitor pops and checks on every Done.
module tb_mul_div_unit;
  import rv32_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Operand_A = '0;
  logic [31:0] Operand_B = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

`ifdef FAST_MUL_EN
  localparam int unsigned MUL_LAT = 0;
`else
  localparam int unsigned MUL_LAT = 32;
`endif
  localparam int unsigned DIV_LAT = 32;

  typedef struct {
    logic [31:0] res;
    int unsigned done_cyc;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int unsigned lat;
    string       name;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int unsigned cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  mul_div_unit dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .Flush     (Flush),
    .Funct3    (Funct3),
    .Operand_A (Operand_A),
    .Operand_B (Operand_B),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Done must match the oldest outstanding expectation
  always @(negedge Clk) begin
    exp_t e;
    if (Rst_n && Done === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_done: actual=Done with result %h required=no Done", Result);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, Result, e.res);
        check({e.name, "_done_cycle"}, cyc, e.done_cyc);
        check({e.name, "_busy_at_done"}, 32'(Busy), 32'd1);
      end
    end
  end

  // Drive one op at the next negedge; accepted at the following posedge
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int unsigned lat, input string name,
                       input bit expect_done);
    exp_t e;
    @(negedge Clk);
    Start = 1'b1; Funct3 = f; Operand_A = a; Operand_B = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    if (expect_done) begin
      e.res = res; e.done_cyc = cyc + lat; e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge Clk); #2;
      k++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL timeout: actual=%0d ops outstanding required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge Clk);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_result", Result, 32'd0);
    Rst_n = 1'b1;
    repeat (2) @(negedge Clk);

    // MUL 7 * -3 with Busy profile
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3", 1'b1);
    @(negedge Clk);
    check("mul_busy_after_accept", 32'(Busy), 32'd1);
    wait_done(40);
    @(negedge Clk);
    check("mul_busy_after_done", 32'(Busy), 32'd0);
    check("mul_done_after_done", 32'(Done), 32'd0);
    check("mul_result_held", Result, 32'hFFFF_FFEB);

    // Directed vectors
    vecs.push_back('{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max"});
    vecs.push_back('{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, "mulh_intmin"});
    vecs.push_back('{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1"});
    vecs.push_back('{OP_MUL,    32'd12345,     32'd1000,      32'd12345000,  MUL_LAT, "mul_pos"});
    vecs.push_back('{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, DIV_LAT, "div_m7_2"});
    vecs.push_back('{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, "rem_m7_2"});
    vecs.push_back('{OP_DIVU,   32'd100,       32'd7,         32'd14,        DIV_LAT, "divu_100_7"});
    vecs.push_back('{OP_REMU,   32'd100,       32'd7,         32'd2,         DIV_LAT, "remu_100_7"});
    vecs.push_back('{OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2"});
    vecs.push_back('{OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         DIV_LAT, "rem_7_m2"});
    vecs.push_back('{OP_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 0,       "divu_by0"});
    vecs.push_back('{OP_REM,    32'd5,         32'd0,         32'd5,         0,       "rem_by0"});
    vecs.push_back('{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0,       "div_ovf"});
    vecs.push_back('{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0,       "rem_ovf"});
    foreach (vecs[i]) begin
      issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, vecs[i].name, 1'b1);
      wait_done(40);
    end

    // Flush mid-divide: accept at edge c0, flush lands on edge c0+10
    issue(OP_DIV, 32'd100, 32'd7, 32'd0, 0, "div_flushed", 1'b0);
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    check("flush_busy", 32'(Busy), 32'd0);
    check("flush_done", 32'(Done), 32'd0);
    check("flush_result_kept", Result, 32'd0);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, "div_after_flush", 1'b1);
    wait_done(40);

    // Start and Flush together: no accept
    @(negedge Clk);
    Start = 1'b1; Flush = 1'b1; Funct3 = OP_DIVU; Operand_A = 32'd9; Operand_B = 32'd3;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0;
    check("start_flush_busy", 32'(Busy), 32'd0);

    // Start during Busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_busy_start", 1'b1);
    repeat (3) @(negedge Clk);
    Start = 1'b1; Funct3 = OP_MUL; Operand_A = 32'd1; Operand_B = 32'd1;
    @(posedge Clk); #1;
    Start = 1'b0;
    wait_done(40);
    repeat (3) @(negedge Clk);
    check("ignored_start_idle", 32'(Busy), 32'd0);

    // Async reset mid-MUL
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_reset", 1'b1);
    repeat (4) @(posedge Clk);
    #2;
    Rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(Busy), 32'd0);
    check("async_rst_done", 32'(Done), 32'd0);
    check("async_rst_result", Result, 32'd0);
    sb.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("post_rst_idle", 32'(Busy), 32'd0);
    issue(OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_after_rst", 1'b1);
    wait_done(40);
    repeat (3) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
